// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: immediate extender feeding a 2-entry in-order result FIFO
module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);
    logic [1:0]       count;
    logic [OUT_W-1:0] d0, d1, zx, sx, res;
    logic             e0, e1, bad, push, pop;

    assign in_ready  = count < 2'd2;
    assign out_valid = count != 2'd0;
    assign out_data  = d0;
    assign out_err   = e0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Extension of the incoming immediate; illegal modes yield zero with err set
    always_comb begin
        zx  = {{(OUT_W-IN_W){1'b0}}, in_imm};
        sx  = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
        bad = in_op > 3'd4;
        res = in_op == 3'd0 ? zx :
              in_op == 3'd1 ? sx :
              in_op == 3'd2 ? {in_imm, {(OUT_W-IN_W){1'b0}}} :
              in_op == 3'd3 ? sx << 2 :
              in_op == 3'd4 ? zx << 2 : '0;
    end

    // FIFO storage: head in d0/e0; vacated slots are zeroed so an empty head reads 0
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            d0    <= '0;
            e0    <= 1'b0;
            d1    <= '0;
            e1    <= 1'b0;
        end else begin
            count <= count + 2'(push) - 2'(pop);
            if (pop) begin
                d0 <= count == 2'd2 ? d1 : (push ? res : '0);
                e0 <= count == 2'd2 ? e1 : (push && bad);
                d1 <= '0;
                e1 <= 1'b0;
            end else if (push && count == 2'd0) begin
                d0 <= res;
                e0 <= bad;
            end else if (push) begin
                d1 <= res;
                e1 <= bad;
            end
        end
    end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed stimulus with a queue-based reference model checked every cycle
module tb_imm_ext_pipe;
    logic        clk = 0, reset = 0, in_valid = 0, out_ready = 0;
    logic [15:0] in_imm = 0;
    logic [2:0]  in_op = 0;
    logic        in_ready, out_valid, out_err;
    logic [31:0] out_data;
    int          checks = 0, errors = 0;
    bit          armed = 0;
    logic [32:0] q[$];

    imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] mdl(logic [15:0] imm, logic [2:0] op);
        longint u = imm;
        longint s = imm[15] ? u - 65536 : u;
        longint r;
        case (op)
            3'd0: r = u;
            3'd1: r = s;
            3'd2: r = u * 65536;
            3'd3: r = s * 4;
            3'd4: r = u * 4;
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, 32'(r)};
    endfunction

    task automatic chk(string n, logic [32:0] a, logic [32:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", n, a, e, $time);
        end
    endtask

    // Reference model: pushes/pops decided from the model's own occupancy
    always @(posedge clk) begin
        if (!reset) begin
            q.delete();
            armed = 1;
        end else begin
            logic do_pop, do_push;
            do_pop  = out_ready && q.size() > 0;
            do_push = in_valid && q.size() < 2;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(mdl(in_imm, in_op));
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready", 33'(in_ready), 33'(q.size() < 2));
            chk("out_valid", 33'(out_valid), 33'(q.size() > 0));
            chk("head", {out_err, out_data}, q.size() > 0 ? q[0] : 33'h0);
        end
    end

    task automatic step(logic [15:0] imm, logic [2:0] op, logic [31:0] ed, logic ee, string n);
        in_valid = 1; in_imm = imm; in_op = op;
        @(posedge clk); #1;
        chk({n, "_valid"}, 33'(out_valid), 33'h1);
        chk({n, "_data"}, 33'(out_data), 33'(ed));
        chk({n, "_err"}, 33'(out_err), 33'(ee));
    endtask

    task automatic idle(int n);
        in_valid = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 33'(out_valid), 33'h0);
        chk("rst_ready", 33'(in_ready), 33'h1);
        chk("rst_data", 33'(out_data), 33'h0);
        reset = 1;
        out_ready = 1;
        step(16'h8001, 3'b000, 32'h00008001, 0, "zext");
        step(16'h8001, 3'b001, 32'hFFFF8001, 0, "sext");
        step(16'h1234, 3'b010, 32'h12340000, 0, "hi");
        step(16'hFFFF, 3'b011, 32'hFFFFFFFC, 0, "br");
        step(16'h4001, 3'b100, 32'h00010004, 0, "zsh");
        step(16'hABCD, 3'b110, 32'h00000000, 1, "ill");
        step(16'h0005, 3'b000, 32'h00000005, 0, "legal");
        idle(2);
        chk("empty_data", 33'(out_data), 33'h0);
        out_ready = 0;
        in_valid = 1; in_imm = 16'h0011; in_op = 3'b000;
        @(posedge clk); #1;
        in_imm = 16'h8000; in_op = 3'b001;
        @(posedge clk); #1;
        in_imm = 16'h00F0; in_op = 3'b010;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", 33'(in_ready), 33'h0);
            chk("bp_stable", 33'(out_data), 33'h00000011);
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk("bp_b", 33'(out_data), 33'hFFFF8000);
        chk("bp_ready_up", 33'(in_ready), 33'h1);
        @(posedge clk); #1;
        in_valid = 0;
        chk("bp_c", 33'(out_data), 33'h00F00000);
        @(posedge clk); #1;
        chk("bp_empty", 33'(out_valid), 33'h0);
        out_ready = 0;
        in_valid = 1; in_imm = 16'h0001; in_op = 3'b100;
        @(posedge clk); #1;
        chk("sim_e", 33'(out_data), 33'h00000004);
        out_ready = 1; in_imm = 16'h7FFF; in_op = 3'b011;
        @(posedge clk); #1;
        chk("sim_valid", 33'(out_valid), 33'h1);
        chk("sim_f", 33'(out_data), 33'h0001FFFC);
        idle(1);
        chk("sim_empty", 33'(out_valid), 33'h0);
        out_ready = 0;
        in_valid = 1; in_imm = 16'h0021; in_op = 3'b000;
        @(posedge clk); #1;
        in_imm = 16'h0022;
        @(posedge clk); #1;
        chk("pre_rst_full", 33'(in_ready), 33'h0);
        reset = 0; out_ready = 1; in_imm = 16'h0033;
        @(posedge clk); #1;
        reset = 1; in_valid = 0;
        chk("mid_rst_valid", 33'(out_valid), 33'h0);
        chk("mid_rst_ready", 33'(in_ready), 33'h1);
        chk("mid_rst_data", 33'(out_data), 33'h0);
        step(16'h0002, 3'b000, 32'h00000002, 0, "post_rst");
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
